// File: rtl/mac_array_seq_pkg.sv
// mac_seq_pkg: shared state encoding and mac_array instruction codes for the tile sequencer
package mac_seq_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, GAP, EXEC, DRAIN, DONE} state_t;
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;
endpackage

// File: rtl/mac_array_seq_if.sv
// mac_array_seq_if: controller/SRAM/mac_array bundle of the tile sequencer (err only with MAC_SEQ_WATCHDOG_EN)
interface mac_array_seq_if #(parameter int col = 8, parameter int aw = 11);
  logic start, stall, rd_en, busy, done;
  logic [aw-1:0] wgt_base, act_base, num_act, rd_addr, out_cnt;
  logic [col-1:0] valid;
  logic [1:0] inst_w;
`ifdef MAC_SEQ_WATCHDOG_EN
  logic err;
`endif
  modport master (
    output start, wgt_base, act_base, num_act, stall, valid,
    input rd_en, rd_addr, inst_w, busy, done, out_cnt
`ifdef MAC_SEQ_WATCHDOG_EN
    , err
`endif
  );
  modport slave (
    input start, wgt_base, act_base, num_act, stall, valid,
    output rd_en, rd_addr, inst_w, busy, done, out_cnt
`ifdef MAC_SEQ_WATCHDOG_EN
    , err
`endif
  );
endinterface

// File: rtl/mac_array_seq_addr_gen.sv
// mac_seq_addr_gen: registered base+counter read address; load zeroes the counter, inc issues base+count
module mac_seq_addr_gen #(parameter int aw = 11) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic          inc,
  input  logic [aw-1:0] base,
  output logic [aw-1:0] addr,
  output logic [aw-1:0] cnt
);
  logic [aw-1:0] n;
  assign n = load ? '0 : cnt;
  // a load on the same cycle as inc issues base+0; sums wrap at 2^aw
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      addr <= '0;
      cnt  <= '0;
    end else if (inc) begin
      addr <= base + n;
      cnt  <= n + aw'(1);
    end else
      cnt <= n;
endmodule

// File: rtl/mac_array_seq.sv
// mac_array_seq: kernel load / gap / execute / drain sequencer for mac_array (optional watchdog: MAC_SEQ_WATCHDOG_EN)
module mac_array_seq
  import mac_seq_pkg::*;
#(parameter int row = 8, parameter int col = 8, parameter int aw = 11) (
  input logic clk,
  input logic reset,
  mac_array_seq_if.slave bus
);
  localparam int TW = $clog2(4 * (row + col) + 1);
  state_t state;
  logic [aw-1:0] wgt_q, act_q, num_q, cnt, cnt_eff, base, out_nxt;
  logic [TW-1:0] tmr;
  logic clr, issue, gap_end, last, hit;
  // read issue decision for this cycle; it becomes rd_en on the next edge
  always_comb begin
    clr = state == IDLE || state == GAP;
    cnt_eff = clr ? '0 : cnt;
    gap_end = state == GAP && tmr == TW'(2 * row - 1);
    issue = (state == IDLE && bus.start) || (state == LOAD && cnt != aw'(col)) ||
            ((state == EXEC || (gap_end && num_q != '0)) && !bus.stall);
    last = issue && cnt_eff + aw'(1) == num_q;
    base = state == IDLE ? bus.wgt_base : state == LOAD ? wgt_q : act_q;
    hit = bus.valid[col-1] && bus.out_cnt != num_q;
    out_nxt = bus.out_cnt + aw'(hit);
  end
  mac_seq_addr_gen #(.aw(aw)) u_addr (
    .clk(clk), .reset(reset), .load(clr), .inc(issue), .base(base), .addr(bus.rd_addr), .cnt(cnt)
  );
  // phase FSM with registered outputs; inst_w tags last cycle's read with its issuing phase
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      wgt_q <= '0;
      act_q <= '0;
      num_q <= '0;
      tmr <= '0;
      bus.rd_en <= 1'b0;
      bus.inst_w <= INST_IDLE;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.out_cnt <= '0;
`ifdef MAC_SEQ_WATCHDOG_EN
      bus.err <= 1'b0;
`endif
    end else begin
      bus.rd_en <= issue;
      bus.inst_w <= !bus.rd_en ? INST_IDLE : state == LOAD ? INST_LOAD : INST_EXEC;
      bus.done <= 1'b0;
      if (state == EXEC || state == DRAIN) bus.out_cnt <= out_nxt;
      case (state)
        IDLE: if (bus.start) begin
          wgt_q <= bus.wgt_base;
          act_q <= bus.act_base;
          num_q <= bus.num_act;
          bus.out_cnt <= '0;
          bus.busy <= 1'b1;
          state <= LOAD;
`ifdef MAC_SEQ_WATCHDOG_EN
          bus.err <= 1'b0;
`endif
        end
        LOAD: if (!issue) begin
          state <= GAP;
          tmr <= '0;
        end
        GAP: if (!gap_end) tmr <= tmr + TW'(1);
          else if (num_q == '0) begin
            state <= DONE;
            bus.done <= 1'b1;
          end else begin
            state <= last ? DRAIN : EXEC;
            tmr <= '0;
          end
        EXEC: if (last) begin
          state <= DRAIN;
          tmr <= '0;
        end
        DRAIN: if (out_nxt == num_q) begin
          state <= DONE;
          bus.done <= 1'b1;
        end
`ifdef MAC_SEQ_WATCHDOG_EN
        else if (hit) tmr <= '0;
        else if (tmr == TW'(4 * (row + col) - 1)) begin
          state <= DONE;
          bus.done <= 1'b1;
          bus.err <= 1'b1;
        end else tmr <= tmr + TW'(1);
`endif
        DONE: begin
          state <= IDLE;
          bus.busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mac_array_seq.sv
// tb_mac_array_seq: scoreboard bench for mac_array_seq (row=col=8, aw=11); cycle c is the period after edge c-1, edge 0 samples start
module tb_mac_array_seq;
  import mac_seq_pkg::*;
  typedef struct {int c; int v; int o;} ev_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  mac_array_seq_if #(.col(8), .aw(11)) bus();
  mac_array_seq #(.row(8), .col(8), .aw(11)) dut (.clk(clk), .reset(reset), .bus(bus));
  int tests = 0, fails = 0, ec = 0, t0e = 1 << 30, mc;
  int st_e[$], va_e[$], sx_e[$], rc[$];
  ev_t q_rd[$], q_in[$], q_dn[$];
  ev_t me;
  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", n, a, e);
    end
  endtask
  task automatic miss(input string n, input int c);
    tests++;
    fails++;
    $display("FAIL %s_unexpected: output seen in cycle %0d with nothing expected", n, c);
  endtask
  function automatic bit has(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction
  function automatic ev_t mk(input int c, input int v, input int o);
    ev_t e;
    e.c = c;
    e.v = v;
    e.o = o;
    return e;
  endfunction
  // drives start/stall/valid for the upcoming edge r (edge-indexed stimulus lists)
  always @(posedge clk) begin
    #1;
    ec++;
    bus.start = (ec + 1 - t0e == 0) || has(sx_e, ec + 1 - t0e);
    bus.stall = has(st_e, ec + 1 - t0e);
    bus.valid = {has(va_e, ec + 1 - t0e), 7'h55};
  end
  // monitor: pops expectations whenever the DUT presents a read, an instruction or done
  always @(negedge clk)
    if (!reset) begin
      mc = ec - t0e + 1;
      if (bus.rd_en) begin
        if (q_rd.size() == 0) miss("rd", mc);
        else begin
          me = q_rd.pop_front();
          chk("rd_cycle", mc, me.c);
          chk("rd_addr", int'(bus.rd_addr), me.v);
        end
      end
      if (bus.inst_w != INST_IDLE) begin
        if (q_in.size() == 0) miss("inst", mc);
        else begin
          me = q_in.pop_front();
          chk("inst_cycle", mc, me.c);
          chk("inst_w", int'(bus.inst_w), me.v);
        end
      end
      if (bus.done) begin
        if (q_dn.size() == 0) miss("done", mc);
        else begin
          me = q_dn.pop_front();
          chk("done_cycle", mc, me.c);
          chk("out_cnt", int'(bus.out_cnt), me.v);
          chk("busy_at_done", int'(bus.busy), 1);
`ifdef MAC_SEQ_WATCHDOG_EN
          chk("err_at_done", int'(bus.err), me.o);
`endif
        end
      end
    end
  task automatic exp_load(input int w);
    for (int k = 0; k < 8; k++) begin
      q_rd.push_back(mk(k + 1, (w + k) % 2048, 0));
      q_in.push_back(mk(k + 2, 1, 0));
    end
  endtask
  task automatic exp_exec(input int a);
    foreach (rc[i]) begin
      q_rd.push_back(mk(rc[i], (a + i) % 2048, 0));
      q_in.push_back(mk(rc[i] + 1, 2, 0));
    end
  endtask
  task automatic arm(input int w, input int a, input int n);
    bus.wgt_base = 11'(w);
    bus.act_base = 11'(a);
    bus.num_act = 11'(n);
    @(negedge clk);
    t0e = ec + 2;
  endtask
  task automatic run_tile(input int w, input int a, input int n, input int dc, input int dv, input int de);
    q_dn.push_back(mk(dc, dv, de));
    arm(w, a, n);
    for (int i = 0; i < 150 && q_dn.size() != 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("pending_rd", q_rd.size(), 0);
    chk("pending_inst", q_in.size(), 0);
    chk("pending_done", q_dn.size(), 0);
    chk("busy_after", int'(bus.busy), 0);
    t0e = 1 << 30;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, int'(bus.rd_en), 0);
    chk({tag, "_rd_addr"}, int'(bus.rd_addr), 0);
    chk({tag, "_inst_w"}, int'(bus.inst_w), 0);
    chk({tag, "_busy"}, int'(bus.busy), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_out_cnt"}, int'(bus.out_cnt), 0);
`ifdef MAC_SEQ_WATCHDOG_EN
    chk({tag, "_err"}, int'(bus.err), 0);
`endif
  endtask
  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.wgt_base = '0;
    bus.act_base = '0;
    bus.num_act = '0;
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("idle");
    // basic tile: valid[7] sampled at edges 30,32,33,35 -> done in cycle 36
    va_e = '{30, 32, 33, 35};
    exp_load('h010);
    rc = '{25, 26, 27, 28};
    exp_exec('h100);
    run_tile('h010, 'h100, 4, 36, 4, 0);
    // stall sampled at edges 25,26 drops reads in cycles 26,27
    st_e = '{25, 26};
    va_e = '{31, 32, 33, 34};
    exp_load('h010);
    rc = '{25, 28, 29, 30};
    exp_exec('h100);
    run_tile('h010, 'h100, 4, 35, 4, 0);
    // num_act=0 skips EXEC entirely
    st_e.delete();
    va_e.delete();
    exp_load('h010);
    run_tile('h010, 'h100, 0, 25, 0, 0);
    // a second start while busy is ignored
    sx_e = '{12};
    va_e = '{30, 32, 33, 35};
    exp_load('h010);
    rc = '{25, 26, 27, 28};
    exp_exec('h100);
    run_tile('h010, 'h100, 4, 36, 4, 0);
    sx_e.delete();
    // address wrap, valids during EXEC saturate out_cnt, DRAIN exits on its first cycle
    st_e = '{25, 26, 27, 28};
    va_e = '{25, 26, 27};
    exp_load('h7FC);
    rc = '{25, 30};
    exp_exec('h7FF);
    run_tile('h7FC, 'h7FF, 2, 31, 2, 0);
    // asynchronous reset in the middle of EXEC
    st_e.delete();
    va_e.delete();
    exp_load('h010);
    rc = '{25};
    exp_exec('h100);
    void'(q_in.pop_back());
    arm('h010, 'h100, 4);
    for (int i = 0; i < 60 && ec - t0e + 1 < 26; i++) begin
      @(posedge clk);
      #2;
    end
    reset = 1'b1;
    #1;
    chk_zero("async_reset");
    t0e = 1 << 30;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("pending_rd_rst", q_rd.size(), 0);
    chk("pending_inst_rst", q_in.size(), 0);
    va_e = '{30, 32, 33, 35};
    exp_load('h010);
    rc = '{25, 26, 27, 28};
    exp_exec('h100);
    run_tile('h010, 'h100, 4, 36, 4, 0);
`ifdef MAC_SEQ_WATCHDOG_EN
    // no valids: DRAIN entered in cycle 28 times out 64 cycles later
    va_e.delete();
    exp_load('h010);
    rc = '{25, 26, 27, 28};
    exp_exec('h100);
    run_tile('h010, 'h100, 4, 92, 0, 1);
    chk("err_sticky", int'(bus.err), 1);
    exp_load('h020);
    run_tile('h020, 'h100, 0, 25, 0, 0);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
